cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/tomasula_types.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/cdb_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo back end: the CDB broadcast record and the
// machine-wide sizing constants.
package tomasula_types;

    localparam int CDB_NUM_REQ = 4;
    localparam int ROB_DEPTH   = 8;
    localparam int TAG_W       = $clog2(ROB_DEPTH);
    localparam int DATA_W      = 32;

    typedef logic [TAG_W-1:0]  rob_tag_t;
    typedef logic [DATA_W-1:0] cdb_data_t;

    typedef struct packed {
        logic      valid;
        rob_tag_t  tag;
        cdb_data_t data;
    } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the search starts at ptr and wraps, so the unit
// just after the last winner has top priority.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic w_found;
    int   w_idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a latch behind.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished result per cycle, broadcasts it
// one cycle later and tracks which ROB entries already hold a result.
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter  int NUM_REQ   = CDB_NUM_REQ,
    parameter  int ROB_DEPTH = tomasula_types::ROB_DEPTH,
    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  rob_tag_t  [NUM_REQ-1:0]        req_tag,
    input  cdb_data_t [NUM_REQ-1:0]        req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           commit,
    input  rob_tag_t                       commit_tag,
    input  logic                           flush,
    output logic                           cdb_valid,
    output rob_tag_t                       cdb_tag,
    output cdb_data_t                      cdb_data,
    output logic [ROB_DEPTH-1:0]           rob_valid
);

    logic [PTR_W-1:0]     r_ptr;
    cdb_t                 r_cdb;
    logic [ROB_DEPTH-1:0] r_rob_valid;

    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_gnt_any;
    logic [PTR_W-1:0]     w_gnt_idx;
    logic [PTR_W-1:0]     w_ptr_next;
    rob_tag_t             w_sel_tag;
    cdb_data_t            w_sel_data;
    logic [ROB_DEPTH-1:0] w_set;
    logic [ROB_DEPTH-1:0] w_clr;

    // Masking the requests (not the grant) keeps ready free of any data/tag path.
    assign w_req = (rst || flush) ? '0 : req_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_gnt_any = |w_gnt;

    always_comb begin
        w_gnt_idx  = '0;
        w_sel_tag  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = PTR_W'(i);
                w_sel_tag  = req_tag[i];
                w_sel_data = req_data[i];
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    assign w_set      = w_gnt_any ? (ROB_DEPTH'(1) << w_sel_tag)  : '0;
    assign w_clr      = commit    ? (ROB_DEPTH'(1) << commit_tag) : '0;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_cdb       <= '0;
            r_rob_valid <= '0;
        end else if (flush) begin
            r_cdb.valid <= 1'b0;
            r_rob_valid <= '0;
        end else begin
            // Set is OR-ed after the clear so a same-tag collision keeps the bit.
            r_rob_valid <= (r_rob_valid & ~w_clr) | w_set;
            r_cdb.valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_cdb.tag  <= w_sel_tag;
                r_cdb.data <= w_sel_data;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    assign cdb_valid = r_cdb.valid;
    assign cdb_tag   = r_cdb.tag;
    assign cdb_data  = r_cdb.data;
    assign rob_valid = r_rob_valid;

endmodule
